// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline register: the captured entry, the
// skid-buffer state, and the capture-time rules applied to incoming entries.
package ex_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_mem_entry_t;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_t;

  // r0 is hardwired to zero, so a write to it is dropped at capture.
  function automatic ex_mem_entry_t sanitize(input ex_mem_entry_t e);
    ex_mem_entry_t r;
    r = e;
    if (e.dest == '0) r.reg_write = 1'b0;
    return r;
  endfunction

  function automatic logic [1:0] occupancy_of(input state_t s);
    logic [1:0] n;
    case (s)
      StOne:   n = 2'd1;
      StFull:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// Valid/ready stream carrying one EX/MEM entry; the master drives valid and
// the entry, the slave drives ready.
interface ex_mem_if;
  import ex_mem_pkg::*;

  logic          valid;
  logic          ready;
  ex_mem_entry_t entry;

  modport master (output valid, output entry, input ready);
  modport slave  (input valid, input entry, output ready);

endinterface

// File: rtl/ex_mem_entry_reg.sv
// Load-enable register for one EX/MEM entry. Reset zeroes everything; clear
// (squash) zeroes only the control bits and keeps the data.
module ex_mem_entry_reg
  import ex_mem_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  ex_mem_entry_t d_i,
  output ex_mem_entry_t q_o
);

  ex_mem_entry_t entry_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else if (clr_i) begin
      entry_q.reg_write  <= 1'b0;
      entry_q.mem_read   <= 1'b0;
      entry_q.mem_write  <= 1'b0;
      entry_q.mem_to_reg <= 1'b0;
    end else if (load_i) begin
      entry_q <= d_i;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer, so MEM
// back-pressure never reaches EX combinationally; also drives the forward view.
module ex_mem_stage
  import ex_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  ex_mem_if.slave           in_bus,
  ex_mem_if.master          out_bus,
  output logic              fwd_valid_o,
  output logic [REG_W-1:0]  fwd_dest_o,
  output logic [DATA_W-1:0] fwd_y_o,
  output logic [1:0]        occupancy_o
);

  state_t        state_q, state_d;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [1:0]    occ_q;

  logic          accept, pop;
  logic          head_load, head_from_skid, skid_load;
  ex_mem_entry_t in_entry, head_d, head_q, skid_q;

  assign accept   = in_bus.valid & in_ready_q;
  assign pop      = out_valid_q & out_bus.ready;
  assign in_entry = sanitize(in_bus.entry);
  assign head_d   = head_from_skid ? skid_q : in_entry;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            head_load = 1'b1;
          end
        end
        StOne: begin
          if (accept && pop) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            state_d        = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Handshake outputs are registered from the next state so in_ready never
  // depends on out_ready or in_valid within a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != StFull);
      out_valid_q <= (state_d != StEmpty);
      occ_q       <= occupancy_of(state_d);
    end
  end

  ex_mem_entry_reg u_head (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .load_i (head_load),
    .d_i    (head_d),
    .q_o    (head_q)
  );

  ex_mem_entry_reg u_skid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .load_i (skid_load),
    .d_i    (in_entry),
    .q_o    (skid_q)
  );

  assign in_bus.ready  = in_ready_q;
  assign out_bus.valid = out_valid_q;
  assign out_bus.entry = head_q;
  assign occupancy_o   = occ_q;

  // Loads are not forwardable: their value only exists after MEM.
  assign fwd_valid_o = out_valid_q & head_q.reg_write & ~head_q.mem_read;
  assign fwd_dest_o  = head_q.dest;
  assign fwd_y_o     = head_q.alu_y;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed vector table, reset-in-stall
// sequence, and random traffic checked against a queue-based reference model.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_dest;
  logic [DATA_W-1:0] fwd_y;
  logic [1:0]        occupancy;

  always #5 clk = ~clk;

  ex_mem_if in_bus ();
  ex_mem_if out_bus ();

  ex_mem_stage dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_bus      (in_bus),
    .out_bus     (out_bus),
    .fwd_valid_o (fwd_valid),
    .fwd_dest_o  (fwd_dest),
    .fwd_y_o     (fwd_y),
    .occupancy_o (occupancy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of at most two held instructions.
  ex_mem_entry_t mq[$];

  task automatic check_model();
    ex_mem_entry_t h;
    chk("m_occ", 32'(occupancy), 32'(mq.size()));
    chk("m_out_valid", 32'(out_bus.valid), 32'(mq.size() > 0));
    chk("m_in_ready", 32'(in_bus.ready), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("m_alu_y", out_bus.entry.alu_y, h.alu_y);
      chk("m_store_data", out_bus.entry.store_data, h.store_data);
      chk("m_dest", 32'(out_bus.entry.dest), 32'(h.dest));
      chk("m_ctrl", 32'({out_bus.entry.reg_write, out_bus.entry.mem_read,
                         out_bus.entry.mem_write, out_bus.entry.mem_to_reg}),
          32'({h.reg_write, h.mem_read, h.mem_write, h.mem_to_reg}));
      chk("m_fwd_valid", 32'(fwd_valid), 32'(h.reg_write && !h.mem_read));
      chk("m_fwd_dest", 32'(fwd_dest), 32'(h.dest));
      chk("m_fwd_y", fwd_y, h.alu_y);
    end else begin
      chk("m_fwd_valid_empty", 32'(fwd_valid), 32'd0);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic tick();
    bit            acc, pp;
    ex_mem_entry_t e;
    @(posedge clk);
    acc = in_bus.valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && out_bus.ready;
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        e = in_bus.entry;
        if (e.reg_write && e.dest == 5'd0) e.reg_write = 1'b0;
        mq.push_back(e);
      end
    end
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst, flush, iv, ordy;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        rw, mr;
    logic        e_ov, e_ir;
    logic [1:0]  e_occ;
    logic        chk_data;
    logic [31:0] e_alu;
    logic        e_rw, e_fwd;
    logic [4:0]  e_fdest;
  } vec_t;

  function automatic vec_t mk(input logic r, f, iv, ordy, input logic [31:0] alu,
                              input logic [4:0] dest, input logic rw, mr,
                              input logic ov, ir, input logic [1:0] occ,
                              input logic cd, input logic [31:0] ealu,
                              input logic erw, efwd, input logic [4:0] efd);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy;
    v.alu = alu; v.dest = dest; v.rw = rw; v.mr = mr;
    v.e_ov = ov; v.e_ir = ir; v.e_occ = occ; v.chk_data = cd;
    v.e_alu = ealu; v.e_rw = erw; v.e_fwd = efwd; v.e_fdest = efd;
    return v;
  endfunction

  task automatic drive(input logic r, f, iv, ordy, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] dest,
                       input logic rw, mr, mw, mtr);
    rst                      = r;
    flush                    = f;
    in_bus.valid             = iv;
    in_bus.entry.alu_y       = alu;
    in_bus.entry.store_data  = sd;
    in_bus.entry.dest        = dest;
    in_bus.entry.reg_write   = rw;
    in_bus.entry.mem_read    = mr;
    in_bus.entry.mem_write   = mw;
    in_bus.entry.mem_to_reg  = mtr;
    out_bus.ready            = ordy;
  endtask

  vec_t vecs[20];

  initial begin
    //              r  f  iv rdy alu           dst rw mr  ov ir occ cd e_alu     erw fwd fd
    vecs[0]  = mk(1, 0, 1, 0, 32'h1111_1111, 1, 1, 0, 0, 1, 0, 1, 32'h0,          0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 0, 32'h1111_1111, 1, 1, 0, 0, 1, 0, 1, 32'h0,          0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 1, 32'hA5A5_A5A5, 3, 1, 0, 1, 1, 1, 1, 32'hA5A5_A5A5,  1, 1, 3);
    vecs[3]  = mk(0, 0, 1, 1, 32'h5A5A_5A5A, 4, 1, 0, 1, 1, 1, 1, 32'h5A5A_5A5A,  1, 1, 4);
    vecs[4]  = mk(0, 0, 1, 1, 32'hFFFF_FFFF, 5, 1, 0, 1, 1, 1, 1, 32'hFFFF_FFFF,  1, 1, 5);
    vecs[5]  = mk(0, 0, 0, 1, 32'h0,         0, 0, 0, 0, 1, 0, 0, 32'h0,          0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 32'h1,         6, 1, 0, 1, 1, 1, 1, 32'h1,          1, 1, 6);
    vecs[7]  = mk(0, 0, 1, 0, 32'h2,         7, 1, 0, 1, 0, 2, 1, 32'h1,          1, 1, 6);
    vecs[8]  = mk(0, 0, 1, 0, 32'h3,         9, 1, 0, 1, 0, 2, 1, 32'h1,          1, 1, 6);
    vecs[9]  = mk(0, 0, 1, 1, 32'h3,         9, 1, 0, 1, 1, 1, 1, 32'h2,          1, 1, 7);
    vecs[10] = mk(0, 0, 1, 1, 32'h3,         9, 1, 0, 1, 1, 1, 1, 32'h3,          1, 1, 9);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 1, 1, 1, 32'h3,          1, 1, 9);
    vecs[12] = mk(0, 0, 1, 1, 32'hCAFE_0001, 10, 1, 0, 1, 1, 1, 1, 32'hCAFE_0001, 1, 1, 10);
    vecs[13] = mk(0, 0, 1, 0, 32'h100,       11, 1, 0, 1, 0, 2, 1, 32'hCAFE_0001, 1, 1, 10);
    vecs[14] = mk(0, 1, 1, 0, 32'hDEAD_0000, 12, 1, 0, 0, 1, 0, 0, 32'h0,         0, 0, 0);
    vecs[15] = mk(0, 0, 0, 1, 32'h0,         0, 0, 0, 0, 1, 0, 0, 32'h0,          0, 0, 0);
    vecs[16] = mk(0, 0, 1, 0, 32'h42,        0, 1, 0, 1, 1, 1, 1, 32'h42,         0, 0, 0);
    vecs[17] = mk(0, 0, 1, 1, 32'h80,        8, 1, 1, 1, 1, 1, 1, 32'h80,         1, 0, 8);
    vecs[18] = mk(0, 0, 1, 1, 32'h99,        8, 1, 0, 1, 1, 1, 1, 32'h99,         1, 1, 8);
    vecs[19] = mk(0, 0, 0, 1, 32'h0,         0, 0, 0, 0, 1, 0, 0, 32'h0,          0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ordy, vecs[i].alu, ~vecs[i].alu,
            vecs[i].dest, vecs[i].rw, vecs[i].mr, 1'b0, vecs[i].mr);
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_bus.valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), 32'(in_bus.ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vecs[i].e_occ));
      chk($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].e_fwd));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_alu_y", i), out_bus.entry.alu_y, vecs[i].e_alu);
        chk($sformatf("v%0d_reg_write", i), 32'(out_bus.entry.reg_write), 32'(vecs[i].e_rw));
        chk($sformatf("v%0d_fwd_dest", i), 32'(fwd_dest), 32'(vecs[i].e_fdest));
      end
    end

    // Reset while full and stalled: both entries lost, every output zero.
    drive(0, 0, 1, 0, 32'h1234_5678, 32'h8765_4321, 5'd13, 1, 0, 1, 1);
    tick();
    tick();
    chk("stall_full_occ", 32'(occupancy), 32'd2);
    drive(1, 0, 1, 0, 32'h0BAD_0BAD, 32'h0, 5'd14, 1, 0, 0, 0);
    tick();
    chk("rst_stall_occ", 32'(occupancy), 32'd0);
    chk("rst_stall_in_ready", 32'(in_bus.ready), 32'd1);
    chk("rst_out_valid", 32'(out_bus.valid), 32'd0);
    chk("rst_entry_zero", 32'(out_bus.entry != '0), 32'd0);
    chk("rst_fwd_y", fwd_y, 32'd0);
    chk("rst_fwd_dest", 32'(fwd_dest), 32'd0);
    drive(0, 0, 0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    tick();
    chk("post_rst_empty", 32'(out_bus.valid), 32'd0);

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      logic [4:0] d;
      d = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      drive(($urandom % 97) == 0, ($urandom % 23) == 0, ($urandom % 4) != 0,
            ($urandom % 3) != 0, $urandom, $urandom, d, 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline stage register between the EX-stage ALU result path (the 32-bit XOR/AND/OR/adder outputs after the result mux) and the MEM stage. It captures the ALU result, store data, destination register and memory/writeback control for one instruction per transfer. It provides a two-entry valid/ready skid buffer so MEM back-pressure never creates a combinational path back into EX. It also exposes a forwarding view of the head entry for the hazard unit.

## Interface
- DATA_W, 32, width of ALU result and store data
- REG_W, 5, register-file address width
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- FLUSH  in  1  synchronous clear of both entries (branch/exception squash)
- IN_VALID  in  1  EX presents an instruction
- IN_READY  out  1  stage can accept this cycle
- ALU_Y  in  DATA_W  ALU result / memory address
- STORE_DATA  in  DATA_W  rt value for SW
- DEST  in  REG_W  writeback register
- REG_WRITE, MEM_READ, MEM_WRITE, MEM_TO_REG  in  1 each  control bits
- OUT_VALID  out  1  head entry valid toward MEM
- OUT_READY  in  1  MEM accepts head
- OUT_ALU_Y, OUT_STORE_DATA  out  DATA_W  head entry data
- OUT_DEST  out  REG_W; OUT_REG_WRITE, OUT_MEM_READ, OUT_MEM_WRITE, OUT_MEM_TO_REG  out  1 each
- FWD_VALID  out  1  head result forwardable
- FWD_DEST  out  REG_W;  FWD_Y  out  DATA_W
- OCCUPANCY  out  2  entries held (0..2)

## Operation
- Two entries: HEAD (drives OUT_*) and SKID. States EMPTY, ONE, FULL; OCCUPANCY = 0/1/2 accordingly.
- accept = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY.
- IN_READY = (state != FULL), decoded from the state register only; no combinational dependence on OUT_READY or IN_VALID.
- OUT_VALID = (state != EMPTY).
- Transitions (FLUSH=0): EMPTY+accept -> ONE, new to HEAD. ONE+accept, no pop -> FULL, new to SKID. ONE+accept+pop -> ONE, new to HEAD. ONE+pop, no accept -> EMPTY. FULL+pop -> ONE, SKID moves to HEAD. Any other combination holds.
- Order strictly preserved; no entry duplicated or dropped except by FLUSH/RST.
- Capture rule: if REG_WRITE=1 and DEST=0, the entry is stored with REG_WRITE=0. All other fields are stored verbatim.
- FWD_VALID = OUT_VALID & OUT_REG_WRITE & ~OUT_MEM_READ; FWD_DEST/FWD_Y mirror OUT_DEST/OUT_ALU_Y.
- FLUSH: next state EMPTY; an accept on the same cycle is discarded; pop handshake on that cycle still counts for MEM. FLUSH has priority over all transitions.
- RST has priority over FLUSH.

## Timing
- Latency: accept at edge N -> OUT_VALID high after edge N (visible in cycle N+1) when empty.
- Throughput: one per cycle with OUT_READY held high.
- Reset values: state EMPTY, OUT_VALID 0, IN_READY 1, all OUT_*/FWD_* data and control 0, OCCUPANCY 0.
- Data fields hold their last value when OUT_VALID=0 (except after reset/flush: flush clears control bits to 0, leaves data).
- Reset or flush mid-stall (FULL, OUT_READY=0): both entries lost, IN_READY=1 next cycle.
- OUT_* held stable while OUT_VALID & ~OUT_READY.

## Structure
- Package ex_mem_pkg: DATA_W/REG_W constants, typedef struct ex_mem_entry_t {alu_y, store_data, dest, reg_write, mem_read, mem_write, mem_to_reg}, typedef enum state_t {EMPTY, ONE, FULL}.
- One sub-module: ex_mem_entry_reg (load-enable + clear register for an ex_mem_entry_t), instantiated for HEAD and SKID. Control FSM and muxing live in ex_mem_stage.

## Test plan
- Reset: RST high 2 cycles with IN_VALID=1 -> OUT_VALID=0, IN_READY=1, OCCUPANCY=0, all outputs 0.
- Streaming: OUT_READY=1, push ALU_Y=0xA5A5A5A5,0x5A5A5A5A,0xFFFFFFFF on consecutive cycles -> same values on OUT_ALU_Y one cycle later each, IN_READY never low.
- Back-pressure: OUT_READY=0, push 3 entries -> first two accepted, OCCUPANCY=2, IN_READY=0; third held; release OUT_READY -> outputs in order 1,2,3.
- Simultaneous in/out in ONE: entry X at head, accept Y with pop -> next cycle head=Y, OCCUPANCY=1.
- Flush in FULL with IN_VALID=1 -> next cycle OUT_VALID=0, OCCUPANCY=0, IN_READY=1, flushed input never appears.
- DEST=0 with REG_WRITE=1, and LW (MEM_READ=1, DEST=8) -> OUT_REG_WRITE=0 / FWD_VALID=0 respectively; ADD to DEST=8 -> FWD_VALID=1, FWD_DEST=8.
